key_schedule_reverse: RTL and testbench
=======================================

// Module: key_schedule_reverse
// PURPOSE
//  Inverse SPECK key schedule for the decryption path. Loads a final round key and
//  the round counter of the last forward update, then steps the schedule backwards.
//  Each earlier round key is emitted over a valid/ready handshake, down to the master
//  key (counter 0). Sits between the key register and the decryption round datapath.
// PARAMETERS
//  BLOCK_SIZE        64   word width; key = {k1,k0}, k0 = key[BLOCK_SIZE-1:0]
//  KEY_SIZE          128  2*BLOCK_SIZE
//  SHIFT_RIGHT_SIZE  8    forward k0 rotate-right amount (alpha)
//  SHIFT_LEFT_SIZE   3    forward k1 rotate-left amount (beta)
//  NR_ROUNDS         32   round keys 0..NR_ROUNDS-1; forward counters 0..NR_ROUNDS-2
// PORTS
//  clk             in   1           system clock, all state on posedge
//  rst_n           in   1           reset, asynchronous, active-low
//  key             in   KEY_SIZE    round key produced by the forward update with round_ctr_start
//  round_ctr_start in   BLOCK_SIZE  counter of that last forward update
//  signal_start    in   1           start request, sampled only in IDLE
//  busy            out  1           high in every state except IDLE
//  out_key         out  KEY_SIZE    previous round key {k1,k0}
//  out_round       out  BLOCK_SIZE  counter value undone to produce out_key
//  out_valid       out  1           out_key/out_round valid
//  out_ready       in   1           consumer accepts when out_valid&&out_ready at posedge
//  finished        out  1           one-cycle pulse after the master key is accepted
//  state_response  out  4           current state encoding, debug only
// BEHAVIOUR
//  Reset (rst_n=0, any time, incl. mid-operation): state=IDLE, k0=k1=ctr=0,
//   out_key=0, out_round=0, out_valid=0, finished=0, busy=0. No partial result survives.
//  Rotations are true circular rotates on BLOCK_SIZE bits. +/- are modulo 2^BLOCK_SIZE.
//  Forward definition undone: k0'=(ROR(k0,a)+k1)^ctr ; k1'=ROL(k1,b)^k0'.
//  States (encoding 0..7):
//   IDLE(0):  finished<=0; on signal_start -> LOAD; otherwise stay.
//   LOAD(1):  k0<=key[63:0], k1<=key[127:64], ctr<=min(round_ctr_start,NR_ROUNDS-2) -> XOR_K1.
//   XOR_K1(2):  k1<=k1^k0 -> ROR_K1_XOR_CTR.
//   ROR_K1_XOR_CTR(3):  k1<=ROR(k1,b), k0<=k0^ctr -> SUB_K0.
//   SUB_K0(4):  k0<=k0-k1 -> ROL_K0.
//   ROL_K0(5):  k0<=ROL(k0,a); out_key<={k1,ROL(k0,a)}; out_round<=ctr;
//               out_valid<=1 -> EMIT.
//   EMIT(6):  hold out_* stable while !out_ready. On handshake: out_valid<=0;
//             if ctr==0 then finished<=1 -> DONE; else ctr<=ctr-1 -> XOR_K1.
//   DONE(7):  finished<=0 -> IDLE.
//  Latency: signal_start sampled at edge E -> out_valid high after edge E+5.
//   Handshake at edge H -> next out_valid after edge H+4.
//   Total keys emitted = clamped ctr+1, in order ctr, ctr-1, ..., 0.
//  signal_start outside IDLE is ignored. Inputs key/round_ctr_start are sampled only in LOAD.
//  out_ready while out_valid=0 has no effect. Back-to-back jobs are allowed:
//   start may be high in the IDLE cycle right after DONE.
//  Clamp: round_ctr_start >= NR_ROUNDS-1 (and any upper bits) is treated as NR_ROUNDS-2.
//  ctr never underflows; the decrement happens only when ctr!=0.
// TESTING
//  1 Single step: key=0x77657b71575d4349_0f1513110f0d0b09, ctr_start=0, out_ready=1
//    -> out_key=0x0f0e0d0c0b0a0908_0706050403020100, out_round=0, valid 5 cycles after
//    start, finished pulse 1 cycle; then IDLE.
//  2 Round trip: forward key_schedule from master key 0x0f0e..0100 with ctr 0..30 -> final
//    key; feed with ctr_start=30 -> 31 outputs, out_round 30..0, each equals the stored
//    forward key; last out_key = master key.
//  3 Backpressure: out_ready low for 10 cycles in EMIT -> out_key/out_round/out_valid stable;
//    out_ready=1 -> exactly one acceptance, ctr decrements once.
//  4 Reset mid-op: assert rst_n=0 in SUB_K0 of step 2 -> all outputs 0 immediately (async),
//    state_response=0; restart -> correct sequence from the beginning.
//  5 Start while busy and clamp: pulse signal_start during EMIT -> ignored.
//    ctr_start=0xFF -> first out_round=30, 31 keys emitted.
//  6 Idle ready: out_ready=1 held in IDLE/compute states -> no spurious out_valid or finished.

Source files
------------

// File: rtl/key_schedule_reverse.sv
// rtl/key_schedule_reverse.sv - inverse SPECK key schedule, steps round keys back to the master key
module key_schedule_reverse #(
  parameter int BLOCK_SIZE       = 64,
  parameter int KEY_SIZE         = 128,
  parameter int SHIFT_RIGHT_SIZE = 8,
  parameter int SHIFT_LEFT_SIZE  = 3,
  parameter int NR_ROUNDS        = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [KEY_SIZE-1:0]   key,
  input  logic [BLOCK_SIZE-1:0] round_ctr_start,
  input  logic                  signal_start,
  output logic                  busy,
  output logic [KEY_SIZE-1:0]   out_key,
  output logic [BLOCK_SIZE-1:0] out_round,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  finished,
  output logic [3:0]            state_response
);

  typedef enum logic [2:0] {
    IDLE           = 3'd0,
    LOAD           = 3'd1,
    XOR_K1         = 3'd2,
    ROR_K1_XOR_CTR = 3'd3,
    SUB_K0         = 3'd4,
    ROL_K0         = 3'd5,
    EMIT           = 3'd6,
    DONE           = 3'd7
  } state_t;

  localparam logic [BLOCK_SIZE-1:0] CTR_MAX = BLOCK_SIZE'(NR_ROUNDS - 2);

  state_t                state, state_d;
  logic [BLOCK_SIZE-1:0] k0, k0_d, k1, k1_d, ctr, ctr_d;
  logic [KEY_SIZE-1:0]   out_key_d;
  logic [BLOCK_SIZE-1:0] out_round_d;
  logic                  out_valid_d, finished_d;

  function automatic logic [BLOCK_SIZE-1:0] ror(input logic [BLOCK_SIZE-1:0] x, input int n);
    return (x >> n) | (x << (BLOCK_SIZE - n));
  endfunction

  function automatic logic [BLOCK_SIZE-1:0] rol(input logic [BLOCK_SIZE-1:0] x, input int n);
    return (x << n) | (x >> (BLOCK_SIZE - n));
  endfunction

  assign busy           = (state != IDLE);
  assign state_response = {1'b0, state};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      k0        <= '0;
      k1        <= '0;
      ctr       <= '0;
      out_key   <= '0;
      out_round <= '0;
      out_valid <= 1'b0;
      finished  <= 1'b0;
    end else begin
      state     <= state_d;
      k0        <= k0_d;
      k1        <= k1_d;
      ctr       <= ctr_d;
      out_key   <= out_key_d;
      out_round <= out_round_d;
      out_valid <= out_valid_d;
      finished  <= finished_d;
    end
  end

  // Each forward round is undone in four steps, in reverse order of its operations.
  always_comb begin
    state_d     = state;
    k0_d        = k0;
    k1_d        = k1;
    ctr_d       = ctr;
    out_key_d   = out_key;
    out_round_d = out_round;
    out_valid_d = out_valid;
    finished_d  = finished;
    case (state)
      IDLE: begin
        finished_d = 1'b0;
        if (signal_start) state_d = LOAD;
      end
      LOAD: begin
        k0_d    = key[BLOCK_SIZE-1:0];
        k1_d    = key[KEY_SIZE-1:BLOCK_SIZE];
        ctr_d   = (round_ctr_start > CTR_MAX) ? CTR_MAX : round_ctr_start;
        state_d = XOR_K1;
      end
      XOR_K1: begin
        k1_d    = k1 ^ k0;
        state_d = ROR_K1_XOR_CTR;
      end
      ROR_K1_XOR_CTR: begin
        k1_d    = ror(k1, SHIFT_LEFT_SIZE);
        k0_d    = k0 ^ ctr;
        state_d = SUB_K0;
      end
      SUB_K0: begin
        k0_d    = k0 - k1;
        state_d = ROL_K0;
      end
      ROL_K0: begin
        k0_d        = rol(k0, SHIFT_RIGHT_SIZE);
        out_key_d   = {k1, rol(k0, SHIFT_RIGHT_SIZE)};
        out_round_d = ctr;
        out_valid_d = 1'b1;
        state_d     = EMIT;
      end
      EMIT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (ctr == '0) begin
            finished_d = 1'b1;
            state_d    = DONE;
          end else begin
            ctr_d   = ctr - BLOCK_SIZE'(1);
            state_d = XOR_K1;
          end
        end
      end
      DONE: begin
        finished_d = 1'b0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_key_schedule_reverse.sv
// tb/tb_key_schedule_reverse.sv - directed bench for key_schedule_reverse
module tb_key_schedule_reverse;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] key;
  logic [63:0]  round_ctr_start;
  logic         signal_start;
  logic         busy;
  logic [127:0] out_key;
  logic [63:0]  out_round;
  logic         out_valid;
  logic         out_ready;
  logic         finished;
  logic [3:0]   state_response;

  int n_vec  = 0;
  int n_fail = 0;
  logic [127:0] fk [0:31];

  always #5 clk = ~clk;

  key_schedule_reverse dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .key             (key),
    .round_ctr_start (round_ctr_start),
    .signal_start    (signal_start),
    .busy            (busy),
    .out_key         (out_key),
    .out_round       (out_round),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .finished        (finished),
    .state_response  (state_response)
  );

  // Forward schedule: k0'=(ROR(k0,8)+k1)^ctr ; k1'=ROL(k1,3)^k0'
  function automatic logic [127:0] fwd(input logic [127:0] k, input logic [63:0] c);
    logic [63:0] a0, a1, n0, n1;
    a0 = k[63:0];
    a1 = k[127:64];
    n0 = ({a0[7:0], a0[63:8]} + a1) ^ c;
    n1 = {a1[60:0], a1[63:61]} ^ n0;
    return {n1, n0};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string tag, input int exp_cycles);
    int cnt;
    cnt = 0;
    while (!out_valid && cnt < 12) begin
      tick();
      cnt++;
    end
    chk({tag, " valid"}, 128'(out_valid), 128'(1));
    chk({tag, " latency"}, 128'(cnt), 128'(exp_cycles));
  endtask

  task automatic start_job(input logic [127:0] k, input logic [63:0] cs);
    key             = k;
    round_ctr_start = cs;
    signal_start    = 1'b1;
    tick();
    signal_start    = 1'b0;
  endtask

  // Full decrypt-side walk from fk[31]; expects keys 30..0 with out_ready held high.
  task automatic run_chain(input string tag, input logic [63:0] cs);
    out_ready = 1'b1;
    start_job(fk[31], cs);
    for (int r = 30; r >= 0; r--) begin
      wait_valid(tag, (r == 30) ? 5 : 4);
      chk({tag, " round"}, 128'(out_round), 128'(r));
      chk({tag, " key"}, out_key, fk[r]);
      tick();
    end
    chk({tag, " finished"}, 128'(finished), 128'(1));
    tick();
    chk({tag, " idle"}, 128'(state_response), 128'(0));
  endtask

  initial begin
    fk[0] = 128'h0f0e0d0c0b0a0908_0706050403020100;
    for (int i = 0; i < 31; i++) fk[i+1] = fwd(fk[i], 64'(i));

    rst_n = 1'b0;
    key = '0;
    round_ctr_start = '0;
    signal_start = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    chk("reset out_key", out_key, 128'h0);
    chk("reset out_valid", 128'(out_valid), 128'h0);
    chk("reset busy", 128'(busy), 128'h0);
    chk("reset state", 128'(state_response), 128'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle ready no valid", 128'(out_valid), 128'h0);
      chk("idle ready no finished", 128'(finished), 128'h0);
    end

    // Single step back to the master key
    start_job(128'h77657b71575d4349_0f1513110f0d0b09, 64'd0);
    chk("t1 load state", 128'(state_response), 128'd1);
    chk("t1 busy", 128'(busy), 128'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t1 no early valid", 128'(out_valid), 128'h0);
      chk("t1 no early finished", 128'(finished), 128'h0);
    end
    tick();
    chk("t1 valid", 128'(out_valid), 128'd1);
    chk("t1 key", out_key, 128'h0f0e0d0c0b0a0908_0706050403020100);
    chk("t1 round", 128'(out_round), 128'd0);
    chk("t1 emit state", 128'(state_response), 128'd6);
    tick();
    chk("t1 finished", 128'(finished), 128'd1);
    chk("t1 valid drop", 128'(out_valid), 128'd0);
    chk("t1 done state", 128'(state_response), 128'd7);
    tick();
    chk("t1 finished pulse", 128'(finished), 128'd0);
    chk("t1 back idle", 128'(busy), 128'd0);

    run_chain("t2 round trip", 64'd30);

    // Reset during SUB_K0 of the second round
    start_job(fk[31], 64'd30);
    wait_valid("t4 first", 5);
    tick();
    tick();
    tick();
    chk("t4 in sub_k0", 128'(state_response), 128'd4);
    #3 rst_n = 1'b0;
    #1;
    chk("t4 async out_key", out_key, 128'h0);
    chk("t4 async out_round", 128'(out_round), 128'h0);
    chk("t4 async out_valid", 128'(out_valid), 128'h0);
    chk("t4 async busy", 128'(busy), 128'h0);
    chk("t4 async state", 128'(state_response), 128'h0);
    tick();
    rst_n = 1'b1;
    tick();
    run_chain("t4 restart", 64'd30);

    // Backpressure, then a start pulse while busy
    out_ready = 1'b0;
    start_job(fk[6], 64'd5);
    wait_valid("t3 first", 5);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t3 hold valid", 128'(out_valid), 128'd1);
      chk("t3 hold round", 128'(out_round), 128'd5);
      chk("t3 hold key", out_key, fk[5]);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t3 accepted", 128'(out_valid), 128'd0);
    chk("t3 recompute", 128'(state_response), 128'd2);
    wait_valid("t3 second", 4);
    chk("t3 one decrement", 128'(out_round), 128'd4);
    chk("t3 second key", out_key, fk[4]);
    key             = '0;
    round_ctr_start = 64'd30;
    signal_start    = 1'b1;
    tick();
    tick();
    signal_start    = 1'b0;
    chk("t5 start ignored state", 128'(state_response), 128'd6);
    chk("t5 start ignored round", 128'(out_round), 128'd4);
    chk("t5 start ignored key", out_key, fk[4]);
    out_ready = 1'b1;
    tick();
    for (int r = 3; r >= 0; r--) begin
      wait_valid("t3 drain", 4);
      chk("t3 drain round", 128'(out_round), 128'(r));
      chk("t3 drain key", out_key, fk[r]);
      tick();
    end
    chk("t3 finished", 128'(finished), 128'd1);
    tick();

    run_chain("t5 clamp ff", 64'hff);
    run_chain("t5 clamp upper", 64'h8000_0000_0000_0000);
    run_chain("t5 clamp 31", 64'd31);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
